mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage controller sitting directly downstream of the EX/MEM pipeline register and upstream of the register file write-back.
- Consumes EX/MEM outputs and runs the data-memory access over a req/ack bus. It stalls the upstream pipeline while an access is outstanding.
- Resolves the branch/jump PC redirect and owns the registered MEM/WB outputs.

Parameters:
- TIMEOUT_CYCLES, 255, number of WAIT cycles without ack before the access is aborted (1..255).
- CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- topc_i  in  1  branch-taken redirect request from EX/MEM.
- jmp_i  in  1  jump redirect request from EX/MEM.
- mem_to_reg_i  in  1  write-back source select.
- mem_read_i  in  1  load request.
- mem_write_i  in  1  store request.
- reg_write_i  in  1  register write enable.
- write_register_i  in  5  destination register.
- alu_result_i  in  32  memory address, or the ALU result to write back.
- read_data_2_i  in  32  store data.
- mux_pc_r_branch_i  in  32  branch/jr target.
- pc_plus_4_i  in  32  link value.
- jmp_shifter_plus_pc_i  in  32  jump target.
- dmem_ack_i  in  1  memory ack; rdata is valid in the same cycle.
- dmem_rdata_i  in  32  memory read data.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word-aligned address.
- dmem_wdata_o  out  32  store data.
- stall_o  out  1  hold EX/MEM and all earlier stages.
- pc_redirect_o  out  1  load the PC with pc_target_o this cycle.
- pc_target_o  out  32  redirect target.
- err_o  out  1  one-cycle pulse on a misaligned access or a timeout.
- mem_to_reg_o  out  1  MEM/WB registered.
- reg_write_o  out  1  MEM/WB registered.
- write_register_o  out  5  MEM/WB registered.
- alu_result_o  out  32  MEM/WB registered.
- read_data_o  out  32  MEM/WB registered load data.
- pc_plus_4_o  out  32  MEM/WB registered link value.

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE and the counter to 0. All registered outputs go to 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, err_o and all MEM/WB outputs. Reset mid-access drops dmem_req_o immediately and the access is abandoned.
- Access condition: access = mem_read_i | mem_write_i. Misaligned = alu_result_i[1:0] != 0.
- IDLE, access and aligned:
  - stall_o=1 combinationally.
  - At the next edge, latch addr, wdata and we (we = mem_write_i; write wins if both read and write are set) into the dmem_* registers.
  - Move to WAIT and clear the counter.
- IDLE, access and misaligned:
  - No bus cycle and no stall.
  - err_o=1 for the next cycle.
  - The instruction retires into MEM/WB with reg_write_o forced to 0.
- IDLE, no access: pass-through with zero stall. MEM/WB captures the inputs at the next edge and read_data_o=0.
- WAIT:
  - dmem_req_o=1 and the address/data/we registers are held stable.
  - If dmem_ack_i=1: stall_o=0. At that edge MEM/WB captures dmem_rdata_i (loads; 0 for stores), req drops, state returns to IDLE.
  - Else: stall_o=1 and the counter increments.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: stall_o=0, err_o pulses next cycle, reg_write_o is forced to 0, state returns to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Minimum load/store latency is 2 cycles: 1 IDLE stall cycle plus 1 WAIT cycle with ack.
- dmem_ack_i in IDLE is ignored.
- Bubble: on any edge where stall_o=1, MEM/WB loads reg_write_o=0 and mem_to_reg_o=0; the other MEM/WB fields hold.
- Redirect: pc_redirect_o = (topc_i | jmp_i) & ~stall_o, combinational. pc_target_o = jmp_i ? jmp_shifter_plus_pc_i : mux_pc_r_branch_i. The redirect fires exactly once, in the cycle the instruction leaves MEM.
- Counter saturates and never wraps.

Test Plan:
- ALU op: reg_write_i=1, write_register_i=5, alu_result_i=0x1234 with no access -> stall_o stays 0; next cycle reg_write_o=1, write_register_o=5, alu_result_o=0x1234, read_data_o=0.
- Load at 0x40, ack on the first WAIT cycle with rdata=0xDEADBEEF -> stall_o high for 1 cycle, dmem_req_o=1 with addr 0x40 and we=0 for 1 cycle; next cycle read_data_o=0xDEADBEEF and reg_write_o=1.
- Store at 0x80 with data 0xA5A5A5A5, ack delayed 3 cycles -> dmem_req_o held 3 cycles with addr, wdata and we stable; stall_o=1 for 3 cycles; reg_write_o=0 during the bubbles.
- Load at 0x42 -> no dmem_req_o, err_o pulses once, reg_write_o=0, stall_o=0.
- TIMEOUT_CYCLES=4 with no ack -> stall releases after the 4th WAIT cycle, err_o pulses, state back to IDLE; a following ALU op passes with zero stall.
- Combined: jmp_i=1 with target 0x400 -> pc_redirect_o=1, pc_target_o=0x400. Reset asserted mid-WAIT -> dmem_req_o=0 immediately and all outputs 0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs the data-memory req/ack access, stalls the upstream
// pipeline while it is outstanding, resolves PC redirects and owns the MEM/WB register.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        topc_i,
    input  logic        jmp_i,
    input  logic        mem_to_reg_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    input  logic [4:0]  write_register_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data_2_i,
    input  logic [31:0] mux_pc_r_branch_i,
    input  logic [31:0] pc_plus_4_i,
    input  logic [31:0] jmp_shifter_plus_pc_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        stall_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_target_o,
    output logic        err_o,
    output logic        mem_to_reg_o,
    output logic        reg_write_o,
    output logic [4:0]  write_register_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] read_data_o,
    output logic [31:0] pc_plus_4_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 access;
    logic                 misaligned;
    logic                 timeout;
    logic                 drop_write;

    // drop_write marks an instruction that retires without writing back (misaligned or timed out)
    always_comb begin
        access     = mem_read_i | mem_write_i;
        misaligned = alu_result_i[1:0] != 2'b00;
        timeout    = wait_cnt == TIMEOUT_LAST;
        stall_o    = 1'b0;
        drop_write = 1'b0;
        if (state == ST_IDLE) begin
            stall_o    = access & ~misaligned;
            drop_write = access & misaligned;
        end else begin
            stall_o    = ~dmem_ack_i & ~timeout;
            drop_write = ~dmem_ack_i & timeout;
        end
        pc_redirect_o = (topc_i | jmp_i) & ~stall_o;
        pc_target_o   = jmp_i ? jmp_shifter_plus_pc_i : mux_pc_r_branch_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            wait_cnt         <= '0;
            dmem_req_o       <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_wdata_o     <= '0;
            err_o            <= 1'b0;
            mem_to_reg_o     <= 1'b0;
            reg_write_o      <= 1'b0;
            write_register_o <= '0;
            alu_result_o     <= '0;
            read_data_o      <= '0;
            pc_plus_4_o      <= '0;
        end else begin
            err_o <= drop_write;

            // A stalled edge inserts a bubble; the data fields simply hold
            if (stall_o) begin
                reg_write_o  <= 1'b0;
                mem_to_reg_o <= 1'b0;
            end else begin
                mem_to_reg_o     <= mem_to_reg_i;
                reg_write_o      <= reg_write_i & ~drop_write;
                write_register_o <= write_register_i;
                alu_result_o     <= alu_result_i;
                pc_plus_4_o      <= pc_plus_4_i;
                read_data_o      <= (state == ST_WAIT && dmem_ack_i && !dmem_we_o) ? dmem_rdata_i : '0;
            end

            if (state == ST_IDLE) begin
                if (access && !misaligned) begin
                    state        <= ST_WAIT;
                    wait_cnt     <= '0;
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= mem_write_i;
                    dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
                    dmem_wdata_o <= read_data_2_i;
                end
            end else begin
                // An ack on the timeout cycle still completes the access normally
                if (dmem_ack_i || timeout) begin
                    state      <= ST_IDLE;
                    dmem_req_o <= 1'b0;
                end else if (wait_cnt != {CNT_WIDTH{1'b1}}) begin
                    wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed instructions push expected retire and
// bus records; independent monitors pop and compare them as the DUT presents them.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        topc_i = 1'b0, jmp_i = 1'b0, mem_to_reg_i = 1'b0;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0, reg_write_i = 1'b0;
    logic [4:0]  write_register_i = '0;
    logic [31:0] alu_result_i = '0, read_data_2_i = '0, mux_pc_r_branch_i = '0;
    logic [31:0] pc_plus_4_i = '0, jmp_shifter_plus_pc_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_req_o, dmem_we_o, stall_o, pc_redirect_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, pc_target_o;
    logic        mem_to_reg_o, reg_write_o;
    logic [4:0]  write_register_o;
    logic [31:0] alu_result_o, read_data_o, pc_plus_4_o;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .topc_i(topc_i), .jmp_i(jmp_i), .mem_to_reg_i(mem_to_reg_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .alu_result_i(alu_result_i),
        .read_data_2_i(read_data_2_i), .mux_pc_r_branch_i(mux_pc_r_branch_i),
        .pc_plus_4_i(pc_plus_4_i), .jmp_shifter_plus_pc_i(jmp_shifter_plus_pc_i),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .stall_o(stall_o), .pc_redirect_o(pc_redirect_o),
        .pc_target_o(pc_target_o), .err_o(err_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .write_register_o(write_register_o),
        .alu_result_o(alu_result_o), .read_data_o(read_data_o), .pc_plus_4_o(pc_plus_4_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic topc, jmp, m2r, mr, mw, rw;
        logic [4:0] wreg;
        logic [31:0] alu, rd2, branch, jmpt, pc4;
    } instr_t;

    typedef struct {
        logic [31:0] stalls;
        logic redirect;
        logic [31:0] target;
        logic err, m2r, rw;
        logic [4:0] wreg;
        logic [31:0] alu, rdata, pc4;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic we;
        logic [31:0] cycles;
    } bus_exp_t;

    int checks = 0;
    int failures = 0;
    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    wb_exp_t  wcur;
    bus_exp_t bcur;
    logic valid_in = 1'b0;
    logic pending = 1'b0;
    logic bubble_pending = 1'b0;
    logic bus_active = 1'b0;
    int stall_cnt = 0;
    int req_cnt = 0;
    int ack_delay = 0;
    int req_seen = 0;
    logic [31:0] ack_rdata = '0;

    function automatic instr_t mk_instr(input logic topc, jmp, m2r, mr, mw, rw, input logic [4:0] wreg,
                                        input logic [31:0] alu, rd2, branch, jmpt, pc4);
        instr_t r;
        r.topc = topc; r.jmp = jmp; r.m2r = m2r; r.mr = mr; r.mw = mw; r.rw = rw;
        r.wreg = wreg; r.alu = alu; r.rd2 = rd2; r.branch = branch; r.jmpt = jmpt; r.pc4 = pc4;
        return r;
    endfunction

    function automatic wb_exp_t mk_wb(input logic [31:0] stalls, input logic redirect, input logic [31:0] target,
                                      input logic err, m2r, rw, input logic [4:0] wreg,
                                      input logic [31:0] alu, rdata, pc4);
        wb_exp_t r;
        r.stalls = stalls; r.redirect = redirect; r.target = target; r.err = err;
        r.m2r = m2r; r.rw = rw; r.wreg = wreg; r.alu = alu; r.rdata = rdata; r.pc4 = pc4;
        return r;
    endfunction

    function automatic bus_exp_t mk_bus(input logic [31:0] addr, wdata, input logic we, input logic [31:0] cycles);
        bus_exp_t r;
        r.addr = addr; r.wdata = wdata; r.we = we; r.cycles = cycles;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic drive(input instr_t in);
        topc_i = in.topc; jmp_i = in.jmp; mem_to_reg_i = in.m2r;
        mem_read_i = in.mr; mem_write_i = in.mw; reg_write_i = in.rw;
        write_register_i = in.wreg; alu_result_i = in.alu; read_data_2_i = in.rd2;
        mux_pc_r_branch_i = in.branch; jmp_shifter_plus_pc_i = in.jmpt; pc_plus_4_i = in.pc4;
    endtask

    // Called just after a rising edge; holds the instruction until it leaves MEM.
    task automatic apply_stimulus(input instr_t in, input wb_exp_t e, input logic has_bus,
                                  input bus_exp_t b, input int delay, input logic [31:0] rdata);
        int n;
        ack_delay = delay;
        ack_rdata = rdata;
        wb_q.push_back(e);
        if (has_bus) bus_q.push_back(b);
        drive(in);
        valid_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o && n < 20);
        if (stall_o) fail_now("retire_timeout");
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_req"}, 32'(dmem_req_o), 32'h0);
        check_output({tag, "_we"}, 32'(dmem_we_o), 32'h0);
        check_output({tag, "_addr"}, dmem_addr_o, 32'h0);
        check_output({tag, "_wdata"}, dmem_wdata_o, 32'h0);
        check_output({tag, "_err"}, 32'(err_o), 32'h0);
        check_output({tag, "_m2r"}, 32'(mem_to_reg_o), 32'h0);
        check_output({tag, "_rw"}, 32'(reg_write_o), 32'h0);
        check_output({tag, "_wreg"}, 32'(write_register_o), 32'h0);
        check_output({tag, "_alu"}, alu_result_o, 32'h0);
        check_output({tag, "_rdata"}, read_data_o, 32'h0);
        check_output({tag, "_pc4"}, pc_plus_4_o, 32'h0);
    endtask

    // Memory model: acks on the ack_delay-th cycle of a request (0 = never)
    always @(posedge clk) begin
        #1;
        if (dmem_req_o) begin
            req_seen++;
            dmem_ack_i   = (ack_delay != 0) && (req_seen == ack_delay);
            dmem_rdata_i = dmem_ack_i ? ack_rdata : 32'h0BAD0BAD;
        end else begin
            req_seen   = 0;
            dmem_ack_i = 1'b0;
        end
    end

    // Bus monitor: one record per request burst, checked every cycle it is held
    always @(negedge clk) begin
        if (dmem_req_o === 1'b1) begin
            if (!bus_active) begin
                bus_active = 1'b1;
                req_cnt = 0;
                if (bus_q.size() == 0) begin
                    fail_now("bus_unexpected_req");
                    bcur = mk_bus(32'h0, 32'h0, 1'b0, 32'h0);
                end else begin
                    bcur = bus_q.pop_front();
                end
            end
            req_cnt++;
            check_output("bus_addr", dmem_addr_o, bcur.addr);
            check_output("bus_wdata", dmem_wdata_o, bcur.wdata);
            check_output("bus_we", 32'(dmem_we_o), 32'(bcur.we));
        end else if (bus_active) begin
            bus_active = 1'b0;
            check_output("bus_req_cycles", req_cnt, bcur.cycles);
        end
    end

    // Retire monitor: counts stall cycles, checks bubbles, redirect and the MEM/WB result
    always @(negedge clk) begin
        if (pending) begin
            check_output("wb_err", 32'(err_o), 32'(wcur.err));
            check_output("wb_mem_to_reg", 32'(mem_to_reg_o), 32'(wcur.m2r));
            check_output("wb_reg_write", 32'(reg_write_o), 32'(wcur.rw));
            check_output("wb_write_register", 32'(write_register_o), 32'(wcur.wreg));
            check_output("wb_alu_result", alu_result_o, wcur.alu);
            check_output("wb_read_data", read_data_o, wcur.rdata);
            check_output("wb_pc_plus_4", pc_plus_4_o, wcur.pc4);
            pending = 1'b0;
        end else begin
            check_output("err_idle", 32'(err_o), 32'h0);
        end
        if (bubble_pending) begin
            check_output("bubble_reg_write", 32'(reg_write_o), 32'h0);
            check_output("bubble_mem_to_reg", 32'(mem_to_reg_o), 32'h0);
            bubble_pending = 1'b0;
        end
        if (valid_in && !reset) begin
            if (stall_o) begin
                stall_cnt++;
                bubble_pending = 1'b1;
                check_output("redirect_during_stall", 32'(pc_redirect_o), 32'h0);
            end else begin
                if (wb_q.size() == 0) begin
                    fail_now("wb_unexpected_retire");
                end else begin
                    wcur = wb_q.pop_front();
                    check_output("stall_cycles", stall_cnt, wcur.stalls);
                    check_output("pc_redirect", 32'(pc_redirect_o), 32'(wcur.redirect));
                    check_output("pc_target", pc_target_o, wcur.target);
                    pending = 1'b1;
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    bus_exp_t no_bus;

    initial begin
        no_bus = mk_bus(32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_all_zero("reset");
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ALU op, no access");
        apply_stimulus(mk_instr(0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h1000),
                       mk_wb(0, 0, 32'h0, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 32'h1000),
                       1'b0, no_bus, 0, 32'h0);

        $display("[TB] load 0x40, ack on first wait cycle");
        apply_stimulus(mk_instr(0, 0, 1, 1, 0, 1, 5'd7, 32'h40, 32'h11111111, 32'h0, 32'h0, 32'h1004),
                       mk_wb(1, 0, 32'h0, 0, 1, 1, 5'd7, 32'h40, 32'hDEADBEEF, 32'h1004),
                       1'b1, mk_bus(32'h40, 32'h11111111, 1'b0, 1), 1, 32'hDEADBEEF);

        $display("[TB] store 0x80, ack after 3 cycles");
        apply_stimulus(mk_instr(0, 0, 0, 0, 1, 0, 5'd0, 32'h80, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h1008),
                       mk_wb(3, 0, 32'h0, 0, 0, 0, 5'd0, 32'h80, 32'h0, 32'h1008),
                       1'b1, mk_bus(32'h80, 32'hA5A5A5A5, 1'b1, 3), 3, 32'hCAFEF00D);

        $display("[TB] misaligned load 0x42");
        apply_stimulus(mk_instr(0, 0, 1, 1, 0, 1, 5'd9, 32'h42, 32'h0, 32'h0, 32'h0, 32'h100C),
                       mk_wb(0, 0, 32'h0, 1, 1, 0, 5'd9, 32'h42, 32'h0, 32'h100C),
                       1'b0, no_bus, 1, 32'h0);

        $display("[TB] load 0x200 with no ack, timeout");
        apply_stimulus(mk_instr(0, 0, 1, 1, 0, 1, 5'd3, 32'h200, 32'h22, 32'h0, 32'h0, 32'h1010),
                       mk_wb(4, 0, 32'h0, 1, 1, 0, 5'd3, 32'h200, 32'h0, 32'h1010),
                       1'b1, mk_bus(32'h200, 32'h22, 1'b0, 4), 0, 32'h0);

        $display("[TB] ALU op after timeout");
        apply_stimulus(mk_instr(0, 0, 0, 0, 0, 1, 5'd4, 32'h5678, 32'h0, 32'h0, 32'h0, 32'h1014),
                       mk_wb(0, 0, 32'h0, 0, 0, 1, 5'd4, 32'h5678, 32'h0, 32'h1014),
                       1'b0, no_bus, 0, 32'h0);

        $display("[TB] jump to 0x400");
        apply_stimulus(mk_instr(0, 1, 0, 0, 0, 1, 5'd31, 32'h2000, 32'h0, 32'h300, 32'h400, 32'h1018),
                       mk_wb(0, 1, 32'h400, 0, 0, 1, 5'd31, 32'h2000, 32'h0, 32'h1018),
                       1'b0, no_bus, 0, 32'h0);

        $display("[TB] taken branch on a load, redirect after the stall");
        apply_stimulus(mk_instr(1, 0, 1, 1, 0, 1, 5'd8, 32'h44, 32'h0, 32'h300, 32'h999, 32'h101C),
                       mk_wb(2, 1, 32'h300, 0, 1, 1, 5'd8, 32'h44, 32'h12345678, 32'h101C),
                       1'b1, mk_bus(32'h44, 32'h0, 1'b0, 2), 2, 32'h12345678);

        $display("[TB] read and write together, write wins");
        apply_stimulus(mk_instr(0, 0, 0, 1, 1, 0, 5'd0, 32'h88, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h1020),
                       mk_wb(1, 0, 32'h0, 0, 0, 0, 5'd0, 32'h88, 32'h0, 32'h1020),
                       1'b1, mk_bus(32'h88, 32'h0F0F0F0F, 1'b1, 1), 1, 32'h00000099);

        $display("[TB] reset during wait");
        ack_delay = 0;
        bus_q.push_back(mk_bus(32'h100, 32'h0, 1'b0, 1));
        drive(mk_instr(0, 0, 1, 1, 0, 1, 5'd6, 32'h100, 32'h0, 32'h0, 32'h0, 32'h3000));
        valid_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        valid_in = 1'b0;
        drive(mk_instr(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ALU op after reset");
        apply_stimulus(mk_instr(0, 0, 0, 0, 0, 1, 5'd2, 32'hABC, 32'h0, 32'h0, 32'h0, 32'h2000),
                       mk_wb(0, 0, 32'h0, 0, 0, 1, 5'd2, 32'hABC, 32'h0, 32'h2000),
                       1'b0, no_bus, 0, 32'h0);

        drive(mk_instr(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
        repeat (4) @(negedge clk);
        #1;
        check_output("wb_queue_drained", wb_q.size(), 32'h0);
        check_output("bus_queue_drained", bus_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
